// File: rtl/myproject_mul_arb.sv
// Arbitrated two-stage signed x unsigned multiplier shared by NUM_REQ requesters.
// Define MYPROJECT_MUL_ARB_RR_EN for round-robin grant; default is fixed priority (lowest index).
module myproject_mul_arb #(
  parameter int NUM_REQ    = 4,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 21,
  parameter int dout_WIDTH = 37
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*din0_WIDTH-1:0]  req_din0,
  input  logic [NUM_REQ*din1_WIDTH-1:0]  req_din1,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [dout_WIDTH-1:0]          rsp_dout,
  output logic [15:0]                    op_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic                  s1_valid;
  logic [din0_WIDTH-1:0] s1_din0;
  logic [din1_WIDTH-1:0] s1_din1;
  logic [ID_W-1:0]       s1_id;
  logic                  s2_valid;
  logic [dout_WIDTH-1:0] s2_dout;
  logic [ID_W-1:0]       s2_id;

  logic                  adv;
  logic                  s1_accept;
  logic                  found;
  logic                  accept;
  logic [ID_W-1:0]       gnt_id;
  int unsigned           idx;
  logic [dout_WIDTH-1:0] a_ext;
  logic [dout_WIDTH-1:0] b_ext;
  logic [dout_WIDTH-1:0] prod;

`ifdef MYPROJECT_MUL_ARB_RR_EN
  logic [ID_W-1:0] ptr;
`endif

  assign adv       = !s2_valid || rsp_ready;
  assign s1_accept = !s1_valid || adv;
  assign accept    = found && s1_accept;
  assign req_ready = (accept && ap_rst_n) ? (NUM_REQ'(1) << gnt_id) : '0;

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign rsp_dout  = s2_dout;

  // Grant search: first asserted valid, scanning upward from the start index.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MYPROJECT_MUL_ARB_RR_EN
      idx = (32'(ptr) + k) % NUM_REQ;
`else
      idx = k;
`endif
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  // Sign-extend din0, zero-extend din1; the modular product is the exact signed result.
  always_comb begin
    a_ext = {{(dout_WIDTH-din0_WIDTH){s1_din0[din0_WIDTH-1]}}, s1_din0};
    b_ext = {{(dout_WIDTH-din1_WIDTH){1'b0}}, s1_din1};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_din0  <= '0;
      s1_din1  <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_dout  <= '0;
      s2_id    <= '0;
      op_count <= '0;
    end else begin
      if (s1_accept) begin
        s1_valid <= accept;
        if (accept) begin
          s1_din0 <= req_din0[int'(gnt_id)*din0_WIDTH +: din0_WIDTH];
          s1_din1 <= req_din1[int'(gnt_id)*din1_WIDTH +: din1_WIDTH];
          s1_id   <= gnt_id;
        end
      end
      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_dout <= prod;
          s2_id   <= s1_id;
        end
      end
      if (s2_valid && rsp_ready)
        op_count <= op_count + 16'd1;
    end
  end

`ifdef MYPROJECT_MUL_ARB_RR_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      ptr <= '0;
    else if (accept)
      ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
  end
`endif

endmodule

// File: tb/tb_myproject_mul_arb.sv
// Self-checking bench for myproject_mul_arb: transaction-level model plus directed literal checks.
module tb_myproject_mul_arb;

  localparam int N  = 4;
  localparam int W0 = 16;
  localparam int W1 = 21;
  localparam int WO = 37;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W0-1:0] req_din0;
  logic [N*W1-1:0] req_din1;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [WO-1:0]   rsp_dout;
  logic [15:0]     op_count;

  int checks = 0;
  int errors = 0;

  myproject_mul_arb #(.NUM_REQ(N), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_dout(rsp_dout), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of accepted transactions, each tagged with its accept cycle.
  typedef struct {
    int            id;
    logic [WO-1:0] dout;
    int            acc;
  } txn_t;

  txn_t          q[$];
  txn_t          t;
  int            cyc = 0;
  int            g;
  int            mptr = 0;
  logic [15:0]   mcnt = '0;
  logic          accept_ok;
  logic          exp_v;
  logic [N-1:0]  exp_ready;
  longint        p;
  logic [W0-1:0] a_op;
  logic [W1-1:0] b_op;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      mcnt = '0;
      mptr = 0;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_id",    64'(rsp_id),    64'd0);
      chk("rst_rsp_dout",  64'(rsp_dout),  64'd0);
      chk("rst_op_count",  64'(op_count),  64'd0);
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
`ifdef MYPROJECT_MUL_ARB_RR_EN
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
`else
        if (g < 0 && req_valid[k]) g = k;
`endif
      end
      accept_ok = (q.size() < 2) || rsp_ready;
      exp_ready = (accept_ok && g >= 0) ? N'(1) << g : '0;
      exp_v = (q.size() > 0) && (cyc - q[0].acc >= 2);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      chk("op_count",  64'(op_count),  64'(mcnt));
      if (exp_v) begin
        chk("rsp_id",   64'(rsp_id),   64'(q[0].id));
        chk("rsp_dout", 64'(rsp_dout), 64'(q[0].dout));
        if (rsp_ready) begin
          void'(q.pop_front());
          mcnt = mcnt + 16'd1;
        end
      end
      if (exp_ready != '0) begin
        a_op   = req_din0[g*W0 +: W0];
        b_op   = req_din1[g*W1 +: W1];
        p      = longint'($signed(a_op)) * longint'(b_op);
        t.id   = g;
        t.dout = p[WO-1:0];
        t.acc  = cyc;
        q.push_back(t);
        mptr = (g + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_din0[i*W0 +: W0] = W0'(a);
    req_din1[i*W1 +: W1] = W1'(b);
  endtask

  logic [WO-1:0] e_dout;
  logic [WO-1:0] hold_dout;
  logic [1:0]    hold_id;
  int            ids[8];
  int            exp_id;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_din0 = '0; req_din1 = '0; rsp_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // Single transaction, latency two cycles
    set_op(0, -3, 5);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    chk("single_not_yet", 64'(rsp_valid), 64'd0);
    step();
    e_dout = 37'(-15);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id",    64'(rsp_id),    64'd0);
    chk("single_dout",  64'(rsp_dout),  64'(e_dout));
    step();
    chk("single_count", 64'(op_count),  64'd1);

    // Extreme operands
    set_op(2, -32768, 2097151);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    e_dout = 37'h10_0000_8000;
    chk("extreme_dout", 64'(rsp_dout), 64'(e_dout));
    chk("extreme_id",   64'(rsp_id),   64'd2);
    step();

    // Reset mid-stream
    for (int i = 0; i < N; i++) set_op(i, (i + 1) * -7 + 3, 1000 * i + 5);
    req_valid = 4'b1111;
    step(); step(); step();
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_count", 64'(op_count),  64'd0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("rst_no_stale", 64'(rsp_valid), 64'd0);

    // Contention: eight acceptances with all requesters valid
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 7) req_valid = '0;
      if (k >= 1) ids[k-1] = int'(rsp_id);
    end
    for (int k = 0; k < 8; k++) begin
`ifdef MYPROJECT_MUL_ARB_RR_EN
      exp_id = k % 4;
`else
      exp_id = 0;
`endif
      chk("contention_id", 64'(ids[k]), 64'(exp_id));
    end
    step(); step();

    // Backpressure with all requesters valid
    req_valid = 4'b1111;
    step(); step(); step();
    rsp_ready = 1'b0;
    #1;
    hold_id = rsp_id;
    hold_dout = rsp_dout;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id",    64'(rsp_id),    64'(hold_id));
      chk("bp_dout",  64'(rsp_dout),  64'(hold_dout));
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step(); step();
    req_valid = '0;
    step(); step(); step(); step();

    // op_count wrap after 65537 responses
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_op(1, 2, 3);
    req_valid = 4'b0010;
    for (int k = 0; k < 65537; k++) step();
    req_valid = '0;
    step(); step();
    chk("wrap_count", 64'(op_count), 64'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
